// File: rtl/multi_clock_gen.sv
// Bank of programmable clock dividers with shadowed, wrap-aligned retargeting,
// fed by a reset sequencer that holds the channels off for RST_CYCLES after release.
module multi_clock_gen #(
    parameter int NCH        = 4,
    parameter int DIV_W      = 8,
    parameter int RST_CYCLES = 16,
    parameter int DEF_DIV    = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     soft_rst,
    input  logic [NCH-1:0]                           en,
    input  logic                                     cfg_wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                         cfg_div,
    input  logic [DIV_W-1:0]                         cfg_phase,
    output logic [NCH-1:0]                           clk_out,
    output logic [NCH-1:0]                           tick,
    output logic                                     rst_out_n,
    output logic                                     ready
);

    localparam int SCW = $clog2(RST_CYCLES + 1);

    typedef enum logic {HOLD, RUN} seq_state_e;

    seq_state_e     state_q, state_d;
    logic [SCW-1:0] scnt_q, scnt_d;

    logic [DIV_W-1:0] div_q  [NCH];
    logic [DIV_W-1:0] div_d  [NCH];
    logic [DIV_W-1:0] ph_q   [NCH];
    logic [DIV_W-1:0] ph_d   [NCH];
    logic [DIV_W-1:0] sdiv_q [NCH];
    logic [DIV_W-1:0] sdiv_d [NCH];
    logic [DIV_W-1:0] sph_q  [NCH];
    logic [DIV_W-1:0] sph_d  [NCH];
    logic [DIV_W-1:0] cnt_q  [NCH];
    logic [DIV_W-1:0] cnt_d  [NCH];

    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] run_q, run_d;
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] hit, wrap;

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic [DIV_W-1:0] eff_ph(input logic [DIV_W-1:0] d,
                                                input logic [DIV_W-1:0] p);
        return (p >= eff_div(d)) ? '0 : p;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HOLD;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // The count saturates at RST_CYCLES; the sample after that releases the system reset.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        if (soft_rst) begin
            state_d = HOLD;
            scnt_d  = '0;
        end else if (state_q == HOLD) begin
            if (scnt_q == SCW'(RST_CYCLES)) begin
                state_d = RUN;
            end else begin
                scnt_d = scnt_q + SCW'(1);
            end
        end
    end

    always_comb begin
        rst_out_n = (state_q == RUN);
        ready     = (state_q == RUN);
    end

    always_comb begin
        hit    = '0;
        wrap   = '0;
        run_d  = '0;
        pend_d = pend_q;
        clk_d  = '0;
        tick_d = '0;
        for (int i = 0; i < NCH; i++) begin
            div_d[i]  = div_q[i];
            ph_d[i]   = ph_q[i];
            sdiv_d[i] = sdiv_q[i];
            sph_d[i]  = sph_q[i];
            cnt_d[i]  = cnt_q[i];
            hit[i]    = cfg_wr && (int'(cfg_ch) == i);
            wrap[i]   = (cnt_q[i] == eff_div(div_q[i]) - DIV_W'(1));
            run_d[i]  = (state_d == RUN) && en[i];

            if (run_q[i] && !run_d[i]) begin
                if (pend_q[i]) begin
                    div_d[i] = sdiv_q[i];
                    ph_d[i]  = sph_q[i];
                end
                if (hit[i]) begin
                    div_d[i] = cfg_div;
                    ph_d[i]  = cfg_phase;
                end
                pend_d[i] = 1'b0;
            end else if (run_q[i]) begin
                // Swap only at the period boundary so the output never sees a runt pulse.
                if (pend_q[i] && wrap[i]) begin
                    div_d[i]  = sdiv_q[i];
                    ph_d[i]   = sph_q[i];
                    pend_d[i] = 1'b0;
                end
                if (hit[i]) begin
                    sdiv_d[i] = cfg_div;
                    sph_d[i]  = cfg_phase;
                    pend_d[i] = 1'b1;
                end
            end else if (hit[i]) begin
                div_d[i] = cfg_div;
                ph_d[i]  = cfg_phase;
            end

            if (!run_d[i] || !run_q[i]) begin
                cnt_d[i] = eff_ph(div_d[i], ph_d[i]);
            end else if (wrap[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end

            clk_d[i]  = run_d[i] && (cnt_d[i] < (eff_div(div_d[i]) >> 1));
            tick_d[i] = run_d[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                div_q[i]  <= DIV_W'(DEF_DIV);
                ph_q[i]   <= '0;
                sdiv_q[i] <= DIV_W'(DEF_DIV);
                sph_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            run_q  <= run_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                div_q[i]  <= div_d[i];
                ph_q[i]   <= ph_d[i];
                sdiv_q[i] <= sdiv_d[i];
                sph_q[i]  <= sph_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed bench for multi_clock_gen: reset release, divide patterns, retarget,
// clamping, out-of-range channel select and soft reset.
module tb_multi_clock_gen;

    logic       clk = 1'b0;
    logic       rstN;
    logic       softRst;
    logic [3:0] en;
    logic [2:0] en3;
    logic       cfgWr;
    logic       cfgWr3;
    logic [1:0] cfgCh;
    logic [7:0] cfgDiv;
    logic [7:0] cfgPhase;
    logic [3:0] clkOut;
    logic [3:0] tickOut;
    logic       rstOutN;
    logic       ready;
    logic [2:0] clkOut3;
    logic [2:0] tickOut3;
    logic       rstOutN3;
    logic       ready3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_clock_gen #(.NCH(4), .DIV_W(8), .RST_CYCLES(16), .DEF_DIV(2)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .soft_rst (softRst),
        .en       (en),
        .cfg_wr   (cfgWr),
        .cfg_ch   (cfgCh),
        .cfg_div  (cfgDiv),
        .cfg_phase(cfgPhase),
        .clk_out  (clkOut),
        .tick     (tickOut),
        .rst_out_n(rstOutN),
        .ready    (ready)
    );

    // Three channels leave cfg_ch value 3 out of range.
    multi_clock_gen #(.NCH(3), .DIV_W(8), .RST_CYCLES(16), .DEF_DIV(2)) dut3 (
        .clk      (clk),
        .rst_n    (rstN),
        .soft_rst (softRst),
        .en       (en3),
        .cfg_wr   (cfgWr3),
        .cfg_ch   (cfgCh),
        .cfg_div  (cfgDiv),
        .cfg_phase(cfgPhase),
        .clk_out  (clkOut3),
        .tick     (tickOut3),
        .rst_out_n(rstOutN3),
        .ready    (ready3)
    );

    task automatic test_reset();
        rstN = 1'b0; softRst = 1'b0; en = 4'b0001; en3 = 3'b000;
        cfgWr = 1'b0; cfgWr3 = 1'b0; cfgCh = 2'd0; cfgDiv = 8'd0; cfgPhase = 8'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rstOutN, ready, clkOut, tickOut} !== 10'b0) begin
                failures++;
                $display("[TB] FAIL reset_active cyc=%0d got rst_out_n=%b ready=%b clk_out=%b tick=%b want all 0",
                         k, rstOutN, ready, clkOut, tickOut);
            end
        end
        rstN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if ({rstOutN, ready, clkOut, tickOut} !== 10'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold cyc=%0d got rst_out_n=%b ready=%b clk_out=%b tick=%b want all 0",
                         k, rstOutN, ready, clkOut, tickOut);
            end
        end
    endtask

    task automatic test_default_divide();
        logic [3:0] expBits;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expBits = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (clkOut !== expBits || tickOut !== expBits || rstOutN !== 1'b1 || ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL default_div cyc=%0d got clk_out=%b tick=%b rst_out_n=%b ready=%b want clk_out=%b tick=%b rst_out_n=1 ready=1",
                         k, clkOut, tickOut, rstOutN, ready, expBits, expBits);
            end
        end
    endtask

    task automatic test_odd_phase();
        bit expClk  [10];
        bit expTick [10];
        expClk  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        expTick = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        cfgWr = 1'b1; cfgCh = 2'd1; cfgDiv = 8'd5; cfgPhase = 8'd3;
        @(negedge clk);
        cfgWr = 1'b0; en = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (clkOut[1] !== expClk[k] || tickOut[1] !== expTick[k]) begin
                failures++;
                $display("[TB] FAIL odd_phase cyc=%0d got clk_out[1]=%b tick[1]=%b want %b %b",
                         k, clkOut[1], tickOut[1], expClk[k], expTick[k]);
            end
        end
        en = 4'b0001;
    endtask

    task automatic test_retarget();
        int  c;
        int  d;
        logic expClk;
        logic expTick;
        en = 4'b0000;
        @(negedge clk);
        cfgWr = 1'b1; cfgCh = 2'd0; cfgDiv = 8'd4; cfgPhase = 8'd0;
        @(negedge clk);
        cfgWr = 1'b0; en = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k < 4) begin
                d = 4; c = k;
            end else begin
                d = 6; c = (k - 4) % 6;
            end
            expClk  = (c < d / 2);
            expTick = (c == 0);
            checks++;
            if (clkOut[0] !== expClk || tickOut[0] !== expTick) begin
                failures++;
                $display("[TB] FAIL retarget cyc=%0d got clk_out[0]=%b tick[0]=%b want %b %b",
                         k, clkOut[0], tickOut[0], expClk, expTick);
            end
            if (k == 1) begin
                cfgWr = 1'b1; cfgCh = 2'd0; cfgDiv = 8'd6; cfgPhase = 8'd0;
            end
            if (k == 2) cfgWr = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic expBit;
        cfgWr = 1'b1; cfgCh = 2'd2; cfgDiv = 8'd0; cfgPhase = 8'd9;
        @(negedge clk);
        cfgWr = 1'b0; en = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expBit = (k % 2 == 0);
            checks++;
            if (clkOut[2] !== expBit || tickOut[2] !== expBit) begin
                failures++;
                $display("[TB] FAIL clamp cyc=%0d got clk_out[2]=%b tick[2]=%b want %b %b",
                         k, clkOut[2], tickOut[2], expBit, expBit);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] expBits;
        cfgWr3 = 1'b1; cfgCh = 2'd3; cfgDiv = 8'd5; cfgPhase = 8'd3;
        @(negedge clk);
        cfgWr3 = 1'b0; en3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expBits = (k % 2 == 0) ? 3'b111 : 3'b000;
            checks++;
            if (clkOut3 !== expBits || tickOut3 !== expBits) begin
                failures++;
                $display("[TB] FAIL out_of_range cyc=%0d got clk_out=%b tick=%b want %b %b",
                         k, clkOut3, tickOut3, expBits, expBits);
            end
        end
    endtask

    task automatic test_soft_reset();
        logic [3:0] expClk  [4];
        logic [3:0] expTick [4];
        expClk  = '{4'b0101, 4'b0001, 4'b0111, 4'b0010};
        expTick = '{4'b0101, 4'b0000, 4'b0110, 4'b0000};
        en = 4'b0111;
        @(negedge clk);
        @(negedge clk);
        softRst = 1'b1;
        @(negedge clk);
        checks++;
        if (rstOutN !== 1'b0 || clkOut !== 4'b0 || tickOut !== 4'b0) begin
            failures++;
            $display("[TB] FAIL soft_rst_entry got rst_out_n=%b clk_out=%b tick=%b want 0 0000 0000",
                     rstOutN, clkOut, tickOut);
        end
        softRst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (rstOutN !== 1'b0 || clkOut !== 4'b0) begin
                failures++;
                $display("[TB] FAIL soft_rst_hold cyc=%0d got rst_out_n=%b clk_out=%b want 0 0000",
                         k, rstOutN, clkOut);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rstOutN !== 1'b1 || clkOut !== expClk[k] || tickOut !== expTick[k]) begin
                failures++;
                $display("[TB] FAIL soft_rst_restart cyc=%0d got rst_out_n=%b clk_out=%b tick=%b want 1 %b %b",
                         k, rstOutN, clkOut, tickOut, expClk[k], expTick[k]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_default_divide();
        test_odd_phase();
        test_retarget();
        test_clamp();
        test_out_of_range();
        test_soft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
